// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the IF/ID hazard unit:
//   REG_ADDR_W_DEFAULT  default register address width
//   MIN_LATENCY/MAX_LATENCY  legal range for load and write-back latencies
//   lat_t               type wide enough for any legal latency value
//   cnt_width()         countdown counter width for a pair of latencies
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_ADDR_W_DEFAULT = 3;

   localparam int MIN_LATENCY = 1;
   localparam int MAX_LATENCY = 7;

   // Width that can hold any latency value up to MAX_LATENCY.
   localparam int LAT_W = $clog2(MAX_LATENCY + 1);

   typedef logic [LAT_W-1:0] lat_t;

   // A counter is loaded with lat-1 and counts to zero, so it only has to
   // hold values up to max(latencies)-1. Sizing for max+1 states keeps the
   // width at least one bit even when both latencies are 1.
   function automatic int cnt_width(input int load_lat, input int wb_lat);
      int m;
      m = (load_lat > wb_lat) ? load_lat : wb_lat;
      if (m < MIN_LATENCY) begin
         m = MIN_LATENCY;
      end
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// -----------------------------------------------------------------------------
// scoreboard_entry
// One per-register countdown counter of the load-use scoreboard.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset, clears the counter
//   load      a tracked write to this register is in ID this cycle
//   load_val  value to load (latency minus one)
//   busy      counter is nonzero, the register result is not yet usable
// -----------------------------------------------------------------------------
module scoreboard_entry
   import hazard_pkg::*;
#(
   parameter int W = LAT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         busy
);

   logic [W-1:0] cnt_q;

   // Reset beats a new write, and a new write always overwrites whatever
   // countdown is in flight: the youngest writer of a register is the one
   // a later reader depends on, so there is no merging with the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// load_use_scoreboard
// Hazard unit between IF and ID. Keeps a countdown per architectural register
// for results that are not yet forwardable and stalls the IF instruction when
// one of its used sources is still outstanding.
// Parameters:
//   REG_ADDR_W    register address width, NUM_REGS = 2**REG_ADDR_W
//   LOAD_LATENCY  stall cycles seen by an immediate dependent of a load (1..7)
//   FWD_EN        1: only loads are tracked; 0: every register write is
//   WB_LATENCY    stall cycles for a non-load write when FWD_EN=0 (1..7)
//   CNT_W         width of the saturating stall counter
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_mem_read               ID instruction is a load
//   id_reg_write              ID instruction writes a register
//   id_dest                   ID destination register
//   if_valid                  IF holds a real instruction
//   if_src1/if_src2           IF source register fields
//   if_src1_used/if_src2_used the corresponding source is really read
//   stall                     hold PC and IF/ID, bubble ID/EX
//   pending                   per-register "countdown nonzero" flags
//   stall_count               saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module load_use_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
   parameter int LOAD_LATENCY = 1,
   parameter int FWD_EN       = 1,
   parameter int WB_LATENCY   = 3,
   parameter int CNT_W        = 16,
   localparam int NUM_REGS    = 2 ** REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_mem_read,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  if_valid,
   input  logic [REG_ADDR_W-1:0] if_src1,
   input  logic [REG_ADDR_W-1:0] if_src2,
   input  logic                  if_src1_used,
   input  logic                  if_src2_used,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   pending,
   output logic [CNT_W-1:0]      stall_count
);

   localparam int CW = cnt_width(LOAD_LATENCY, WB_LATENCY);

   // Counters hold lat-1: the cycle the producer sits in ID is the first
   // stall cycle and is caught by the direct ID comparison below.
   localparam lat_t LOAD_LAT_M1 = lat_t'(LOAD_LATENCY - 1);
   localparam lat_t WB_LAT_M1   = lat_t'(WB_LATENCY - 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT_M1);
   localparam logic [CW-1:0] WB_VAL   = CW'(WB_LAT_M1);

   logic            tracked_write;
   logic [CW-1:0]   load_val;
   logic [NUM_REGS-1:0] busy_vec;
   logic            src1_match;
   logic            src2_match;
   logic [CNT_W-1:0] stall_cnt_q;

   // An ID instruction needs tracking when its result cannot be forwarded in
   // time: loads always, and any register write when forwarding is disabled.
   // Writes to r0 are discarded by the register file, so they never count.
   // A load that also claims reg_write is timed as a load.
   always_comb begin
      tracked_write = id_valid && (id_dest != '0) &&
                      (id_mem_read || ((FWD_EN == 0) && id_reg_write));
      load_val      = id_mem_read ? LOAD_VAL : WB_VAL;
   end

   // r0 is hardwired zero and never has a counter.
   assign busy_vec[0] = 1'b0;

   genvar r;
   generate
      for (r = 1; r < NUM_REGS; r++) begin : g_entry
         scoreboard_entry #(
            .W (CW)
         ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (tracked_write && (id_dest == REG_ADDR_W'(r))),
            .load_val (load_val),
            .busy     (busy_vec[r])
         );
      end
   endgenerate

   assign pending = busy_vec;

   // A source is hazardous if an older producer is still counting down, or
   // if the producer is right now in ID and has not reached a counter yet.
   // Unused source fields hold garbage and are ignored, as is r0.
   always_comb begin
      src1_match = if_src1_used && (if_src1 != '0) &&
                   (busy_vec[if_src1] || (tracked_write && (id_dest == if_src1)));
      src2_match = if_src2_used && (if_src2 != '0) &&
                   (busy_vec[if_src2] || (tracked_write && (id_dest == if_src2)));
      stall      = !rst && if_valid && (src1_match || src2_match);
   end

   // Performance counter of stall cycles; it sticks at all-ones rather than
   // wrapping so a long run never reports a misleadingly small number.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_load_use_scoreboard
// Three instances with different parameter sets:
//   0: defaults (LOAD_LATENCY=1, FWD_EN=1)
//   1: LOAD_LATENCY=3, FWD_EN=0, WB_LATENCY=3, CNT_W=4
//   2: LOAD_LATENCY=4, FWD_EN=1
// Each stimulus vector targets one instance and carries hand-computed
// expected stall/pending/stall_count for that cycle.
// -----------------------------------------------------------------------------
module tb_load_use_scoreboard;

   typedef struct {
      int          inst;
      logic        stall;
      logic [7:0]  pending;
      logic [15:0] count;
      string       name;
   } exp_t;

   logic clk = 1'b0;

   logic       rst_v       [3];
   logic       id_valid_v  [3];
   logic       id_mr_v     [3];
   logic       id_rw_v     [3];
   logic [2:0] id_dest_v   [3];
   logic       if_valid_v  [3];
   logic [2:0] if_src1_v   [3];
   logic [2:0] if_src2_v   [3];
   logic       if_u1_v     [3];
   logic       if_u2_v     [3];
   logic       stall_v     [3];
   logic [7:0] pending_v   [3];
   logic [15:0] count0;
   logic [3:0]  count1;
   logic [15:0] count2;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   // 10 ns clock for all instances.
   always #5 clk = ~clk;

   load_use_scoreboard u_dut0 (
      .clk(clk), .rst(rst_v[0]), .id_valid(id_valid_v[0]), .id_mem_read(id_mr_v[0]),
      .id_reg_write(id_rw_v[0]), .id_dest(id_dest_v[0]), .if_valid(if_valid_v[0]),
      .if_src1(if_src1_v[0]), .if_src2(if_src2_v[0]), .if_src1_used(if_u1_v[0]),
      .if_src2_used(if_u2_v[0]), .stall(stall_v[0]), .pending(pending_v[0]),
      .stall_count(count0)
   );

   load_use_scoreboard #(
      .LOAD_LATENCY(3), .FWD_EN(0), .WB_LATENCY(3), .CNT_W(4)
   ) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .id_valid(id_valid_v[1]), .id_mem_read(id_mr_v[1]),
      .id_reg_write(id_rw_v[1]), .id_dest(id_dest_v[1]), .if_valid(if_valid_v[1]),
      .if_src1(if_src1_v[1]), .if_src2(if_src2_v[1]), .if_src1_used(if_u1_v[1]),
      .if_src2_used(if_u2_v[1]), .stall(stall_v[1]), .pending(pending_v[1]),
      .stall_count(count1)
   );

   load_use_scoreboard #(
      .LOAD_LATENCY(4), .FWD_EN(1)
   ) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .id_valid(id_valid_v[2]), .id_mem_read(id_mr_v[2]),
      .id_reg_write(id_rw_v[2]), .id_dest(id_dest_v[2]), .if_valid(if_valid_v[2]),
      .if_src1(if_src1_v[2]), .if_src2(if_src2_v[2]), .if_src1_used(if_u1_v[2]),
      .if_src2_used(if_u2_v[2]), .stall(stall_v[2]), .pending(pending_v[2]),
      .stall_count(count2)
   );

   // Put every instance into an idle, non-reset state.
   task automatic idleAll();
      for (int k = 0; k < 3; k++) begin
         rst_v[k]      = 1'b0;
         id_valid_v[k] = 1'b0;
         id_mr_v[k]    = 1'b0;
         id_rw_v[k]    = 1'b0;
         id_dest_v[k]  = 3'd0;
         if_valid_v[k] = 1'b0;
         if_src1_v[k]  = 3'd0;
         if_src2_v[k]  = 3'd0;
         if_u1_v[k]    = 1'b0;
         if_u2_v[k]    = 1'b0;
      end
   endtask

   // Drive one cycle of inputs on instance k, queue the expected outputs for
   // that cycle, then move to just after the next rising edge.
   task automatic applyStimulus(
      input int k, input logic rs,
      input logic idv, input logic mr, input logic rw, input logic [2:0] dest,
      input logic ifv, input logic [2:0] s1, input logic u1,
      input logic [2:0] s2, input logic u2,
      input logic es, input logic [7:0] ep, input logic [15:0] ec,
      input string nm);
      exp_t e;
      idleAll();
      rst_v[k]      = rs;
      id_valid_v[k] = idv;
      id_mr_v[k]    = mr;
      id_rw_v[k]    = rw;
      id_dest_v[k]  = dest;
      if_valid_v[k] = ifv;
      if_src1_v[k]  = s1;
      if_u1_v[k]    = u1;
      if_src2_v[k]  = s2;
      if_u2_v[k]    = u2;
      e.inst    = k;
      e.stall   = es;
      e.pending = ep;
      e.count   = ec;
      e.name    = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Compare one expected entry against the addressed instance.
   task automatic checkOutput(input exp_t e);
      logic        act_stall;
      logic [7:0]  act_pend;
      logic [15:0] act_cnt;
      act_stall = stall_v[e.inst];
      act_pend  = pending_v[e.inst];
      case (e.inst)
         0:       act_cnt = count0;
         1:       act_cnt = {12'd0, count1};
         default: act_cnt = count2;
      endcase
      n_compared++;
      if (act_stall !== e.stall) begin
         n_mismatched++;
         $display("[TB] FAIL %s.stall inst%0d: got %b expected %b", e.name, e.inst, act_stall, e.stall);
      end
      n_compared++;
      if (act_pend !== e.pending) begin
         n_mismatched++;
         $display("[TB] FAIL %s.pending inst%0d: got %h expected %h", e.name, e.inst, act_pend, e.pending);
      end
      n_compared++;
      if (act_cnt !== e.count) begin
         n_mismatched++;
         $display("[TB] FAIL %s.stall_count inst%0d: got %0d expected %0d", e.name, e.inst, act_cnt, e.count);
      end
   endtask

   // Outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      idleAll();
      for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
      @(posedge clk);
      #1;

      // Reset state of every instance.
      applyStimulus(0, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd0, "rst0");
      applyStimulus(1, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd0, "rst1");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd0, "rst2");

      // Defaults: load r3, IF reads r3 on src2 -> one stall cycle.
      applyStimulus(0, 0, 1,1,1,3'd3, 1,3'd1,1,3'd3,1, 1, 8'h00, 16'd0, "ld1_c0");
      applyStimulus(0, 0, 0,0,0,3'd0, 1,3'd1,1,3'd3,1, 0, 8'h00, 16'd1, "ld1_c1");
      applyStimulus(0, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd1, "ld1_c2");
      // Store and ALU write with forwarding on never stall.
      applyStimulus(0, 0, 1,0,0,3'd3, 1,3'd3,1,3'd0,0, 0, 8'h00, 16'd1, "st_c0");
      applyStimulus(0, 0, 0,0,0,3'd0, 1,3'd3,1,3'd0,0, 0, 8'h00, 16'd1, "st_c1");
      applyStimulus(0, 0, 1,0,1,3'd3, 1,3'd3,1,3'd3,1, 0, 8'h00, 16'd1, "alu_fwd");

      // LOAD_LATENCY=3: load r5, dependent one cycle behind -> 2 stalls.
      applyStimulus(1, 0, 1,1,0,3'd5, 1,3'd1,1,3'd2,1, 0, 8'h00, 16'd0, "ld3_c0");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd5,1,3'd0,0, 1, 8'h20, 16'd0, "ld3_c1");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd5,1,3'd0,0, 1, 8'h20, 16'd1, "ld3_c2");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd5,1,3'd0,0, 0, 8'h00, 16'd2, "ld3_c3");
      // Load to r0 never stalls and leaves nothing pending.
      applyStimulus(1, 0, 1,1,0,3'd0, 1,3'd0,1,3'd0,1, 0, 8'h00, 16'd2, "ldr0_c0");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd0,1,3'd0,1, 0, 8'h00, 16'd2, "ldr0_c1");

      // FWD_EN=0, WB_LATENCY=3: ALU write r2, dependent in IF -> 3 stalls.
      applyStimulus(1, 0, 1,0,1,3'd2, 1,3'd2,1,3'd0,0, 1, 8'h00, 16'd2, "wb_c0");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd2,1,3'd0,0, 1, 8'h04, 16'd3, "wb_c1");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd2,1,3'd0,0, 1, 8'h04, 16'd4, "wb_c2");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd2,1,3'd0,0, 0, 8'h00, 16'd5, "wb_c3");
      // Unused src2 naming r2 does not stall.
      applyStimulus(1, 0, 1,0,1,3'd2, 1,3'd1,1,3'd2,0, 0, 8'h00, 16'd5, "unused_c0");
      applyStimulus(1, 0, 0,0,0,3'd0, 1,3'd1,1,3'd2,0, 0, 8'h04, 16'd5, "unused_c1");
      applyStimulus(1, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h04, 16'd5, "unused_c2");
      applyStimulus(1, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd5, "unused_c3");

      // CNT_W=4: stall held 20 cycles, counter sticks at 15.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0, 1,0,1,3'd4, 1,3'd4,1,3'd0,0, 1,
                       (i == 0) ? 8'h00 : 8'h10,
                       16'(((5 + i) > 15) ? 15 : (5 + i)), "sat");
      end
      applyStimulus(1, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h10, 16'd15, "sat_end");
      applyStimulus(1, 1, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h10, 16'd15, "sat_rst");
      applyStimulus(1, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd0, "sat_post");

      // LOAD_LATENCY=4: load r6, if_valid=0 masks the hazard, then a
      // reloading load r6 when the counter is at 1.
      applyStimulus(2, 0, 1,1,1,3'd6, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd0, "rl_c0");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd6,1,3'd0,0, 0, 8'h40, 16'd0, "rl_c1");
      applyStimulus(2, 0, 0,0,0,3'd0, 1,3'd6,1,3'd0,0, 1, 8'h40, 16'd0, "rl_c2");
      applyStimulus(2, 0, 1,1,0,3'd6, 0,3'd0,0,3'd0,0, 0, 8'h40, 16'd1, "rl_c3");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h40, 16'd1, "rl_c4");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h40, 16'd1, "rl_c5");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h40, 16'd1, "rl_c6");
      applyStimulus(2, 0, 0,0,0,3'd0, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd1, "rl_c7");
      // Reset mid-countdown clears everything and forces stall low.
      applyStimulus(2, 0, 1,1,0,3'd6, 0,3'd0,0,3'd0,0, 0, 8'h00, 16'd1, "mr_c0");
      applyStimulus(2, 1, 0,0,0,3'd0, 1,3'd6,1,3'd0,0, 0, 8'h40, 16'd1, "mr_rst");
      applyStimulus(2, 0, 0,0,0,3'd0, 1,3'd6,1,3'd0,0, 0, 8'h00, 16'd0, "mr_post");

      idleAll();
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
